// File: rtl/scroll_ctrl.sv
// scroll_ctrl: sequencer for the six-digit scrolling "GO BUFFS" message.
// Produces the six 4-bit character codes consumed by external per-digit
// seven-segment character decoders (HEX5..HEX0).
//
// Parameters:
//   MSG_LEN    - number of character codes in the message (6..16)
//   DIV_BASE   - clock cycles per scroll step at speed=0
//   CNT_W      - prescaler width, 2**CNT_W > DIV_BASE
//   HOLD_TICKS - extra ticks to dwell when the offset returns to 0 (0 = off)
//
// Ports:
//   clk    in   system clock, all logic on posedge
//   reset  in   synchronous active-high reset
//   run    in   level: 1 = scroll, 0 = stop
//   dir    in   0 = offset increments, 1 = offset decrements
//   speed  in   [1:0] tick period = DIV_BASE >> speed cycles
//   step   in   rising edge advances one position while stopped
//   a..f   out  [3:0] char codes for HEX5..HEX0 = (offset+5..0) mod MSG_LEN
//   tick   out  one-cycle pulse on prescaler expiry (RUN/HOLD only)
//   state  out  [1:0] 0 = STOP, 1 = RUN, 2 = HOLD
module scroll_ctrl #(
  parameter int MSG_LEN    = 10,
  parameter int DIV_BASE   = 50000000,
  parameter int CNT_W      = 26,
  parameter int HOLD_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       dir,
  input  logic [1:0] speed,
  input  logic       step,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] c,
  output logic [3:0] d,
  output logic [3:0] e,
  output logic [3:0] f,
  output logic       tick,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [3:0] LAST    = 4'(MSG_LEN - 1);
  localparam bit         HOLD_EN = (HOLD_TICKS > 0);
  localparam int         DW_W    = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS);

  state_t             st_q, st_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [DW_W-1:0]    dwell_q, dwell_n;
  logic [3:0]         off_q, off_n;
  logic               tick_q, tick_n;
  logic               step_q;

  logic [31:0]        limit;
  logic [31:0]        limit_m1;
  logic               expire;
  logic               step_edge;
  logic               last_dwell;
  logic [3:0]         adv_off;

  // Wrapping add of a small constant to an in-range offset; the result is
  // always < MSG_LEN because both operands are below MSG_LEN.
  function automatic logic [3:0] wrap_add(input logic [3:0] v, input logic [3:0] k);
    logic [4:0] s;
    s = {1'b0, v} + {1'b0, k};
    if (s >= 5'(MSG_LEN)) s = s - 5'(MSG_LEN);
    return s[3:0];
  endfunction

  // Next offset for one advance; dir is sampled at the advance edge.
  function automatic logic [3:0] advance(input logic [3:0] v, input logic down);
    if (down) return (v == 4'd0) ? LAST : v - 4'd1;
    else      return (v == LAST) ? 4'd0 : v + 4'd1;
  endfunction

  // Comparing with >= (not ==) lets a mid-count speed increase fire at once.
  assign limit      = 32'(DIV_BASE) >> speed;
  assign limit_m1   = (limit == 32'd0) ? 32'd0 : limit - 32'd1;
  assign expire     = (32'(cnt_q) >= limit_m1);
  assign step_edge  = step & ~step_q;
  assign last_dwell = ((32'(dwell_q) + 32'd1) >= 32'(HOLD_TICKS));
  assign adv_off    = advance(off_q, dir);

  always_comb begin
    st_n    = st_q;
    cnt_n   = cnt_q;
    dwell_n = dwell_q;
    off_n   = off_q;
    tick_n  = 1'b0;
    unique case (st_q)
      ST_STOP: begin
        cnt_n = '0;
        if (run) begin
          st_n = ST_RUN;
        end else if (step_edge) begin
          off_n = adv_off;
        end
      end
      ST_RUN: begin
        // Stopping wins over a coincident expiry: no advance, no tick.
        if (!run) begin
          st_n  = ST_STOP;
          cnt_n = '0;
        end else if (expire) begin
          cnt_n  = '0;
          tick_n = 1'b1;
          off_n  = adv_off;
          if (HOLD_EN && adv_off == 4'd0) begin
            st_n    = ST_HOLD;
            dwell_n = '0;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!run) begin
          st_n  = ST_STOP;
          cnt_n = '0;
        end else if (expire) begin
          cnt_n  = '0;
          tick_n = 1'b1;
          if (last_dwell) begin
            st_n    = ST_RUN;
            dwell_n = '0;
          end else begin
            dwell_n = dwell_q + DW_W'(1);
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        st_n  = ST_STOP;
        cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= ST_STOP;
      cnt_q   <= '0;
      dwell_q <= '0;
      off_q   <= 4'd0;
      tick_q  <= 1'b0;
      step_q  <= 1'b0;
      a       <= 4'd5;
      b       <= 4'd4;
      c       <= 4'd3;
      d       <= 4'd2;
      e       <= 4'd1;
    end else begin
      st_q    <= st_n;
      cnt_q   <= cnt_n;
      dwell_q <= dwell_n;
      off_q   <= off_n;
      tick_q  <= tick_n;
      step_q  <= step;
      // Digit codes are registered from the next offset so they change on
      // the same edge as the offset itself.
      a       <= wrap_add(off_n, 4'd5);
      b       <= wrap_add(off_n, 4'd4);
      c       <= wrap_add(off_n, 4'd3);
      d       <= wrap_add(off_n, 4'd2);
      e       <= wrap_add(off_n, 4'd1);
    end
  end

  assign f     = off_q;
  assign tick  = tick_q;
  assign state = st_q;

endmodule

// File: tb/tb_scroll_ctrl.sv
module tb_scroll_ctrl;

  localparam int MSG_LEN    = 10;
  localparam int DIV_BASE   = 8;
  localparam int CNT_W      = 4;
  localparam int HOLD_TICKS = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       dir = 1'b0;
  logic [1:0] speed = 2'd0;
  logic       step = 1'b0;
  logic [3:0] a, b, c, d, e, f;
  logic       tick;
  logic [1:0] state;

  always #5 clk = ~clk;

  scroll_ctrl #(
    .MSG_LEN(MSG_LEN), .DIV_BASE(DIV_BASE), .CNT_W(CNT_W), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .dir(dir), .speed(speed), .step(step),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .tick(tick), .state(state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Tracks the message position and the time since the last scroll event
  // in plain integers; digit codes are derived with modulo arithmetic.
  int m_off = 0, m_st = 0, m_cnt = 0, m_dw = 0, m_tick = 0, m_sq = 0;

  task automatic model_clock();
    int lim;
    bit edge_s, expire;
    if (reset) begin
      m_off = 0; m_st = 0; m_cnt = 0; m_dw = 0; m_tick = 0; m_sq = 0;
      return;
    end
    edge_s = step && (m_sq == 0);
    lim    = DIV_BASE >> speed;
    if (lim < 1) lim = 1;
    expire = (m_cnt >= lim - 1);
    m_tick = 0;
    if (m_st == 0) begin
      m_cnt = 0;
      if (run) m_st = 1;
      else if (edge_s) m_off = dir ? (m_off + MSG_LEN - 1) % MSG_LEN : (m_off + 1) % MSG_LEN;
    end else if (!run) begin
      m_st = 0; m_cnt = 0;
    end else if (!expire) begin
      m_cnt++;
    end else begin
      m_cnt = 0; m_tick = 1;
      if (m_st == 1) begin
        m_off = dir ? (m_off + MSG_LEN - 1) % MSG_LEN : (m_off + 1) % MSG_LEN;
        if (m_off == 0 && HOLD_TICKS > 0) begin m_st = 2; m_dw = 0; end
      end else begin
        m_dw++;
        if (m_dw >= HOLD_TICKS) begin m_st = 1; m_dw = 0; end
      end
    end
    m_sq = step;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    logic [3:0] exp_q[$];
    for (int k = 5; k >= 0; k--) exp_q.push_back(4'((m_off + k) % MSG_LEN));
    check("a", a, exp_q[0]);
    check("b", b, exp_q[1]);
    check("c", c, exp_q[2]);
    check("d", d, exp_q[3]);
    check("e", e, exp_q[4]);
    check("f", f, exp_q[5]);
    check("tick", tick, m_tick);
    check("state", state, m_st);
  endtask

  // ---------------- driver ----------------
  task automatic clock_n(input int n);
    for (int i = 0; i < n; i++) begin
      model_clock();
      @(posedge clk);
      #1;
      check_model();
    end
  endtask

  typedef struct {
    bit       rst;
    bit       run;
    bit       dir;
    bit [1:0] speed;
    bit       step;
    int       ncyc;
    int       exp_f;
    int       exp_state;
    int       exp_tick;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit ru, bit di, bit [1:0] sp, bit st, int n,
                              int ef, int es, int et);
    vec_t v;
    v.rst = r; v.run = ru; v.dir = di; v.speed = sp; v.step = st; v.ncyc = n;
    v.exp_f = ef; v.exp_state = es; v.exp_tick = et;
    return v;
  endfunction

  initial begin
    // Reset and idle
    vecs.push_back(mk(1,0,0,0,0, 1, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,50, 0,0,0));
    // Run at speed 0: tick period 8, first tick at the 8th RUN cycle
    vecs.push_back(mk(0,1,0,0,0, 1, 0,1,0));
    vecs.push_back(mk(0,1,0,0,0, 7, 0,1,0));
    vecs.push_back(mk(0,1,0,0,0, 1, 1,1,1));
    vecs.push_back(mk(0,1,0,0,0, 7, 1,1,0));
    vecs.push_back(mk(0,1,0,0,0, 1, 2,1,1));
    vecs.push_back(mk(0,1,0,0,0,24, 5,1,1));
    vecs.push_back(mk(0,1,0,0,0,40, 0,2,1));
    vecs.push_back(mk(0,1,0,0,0, 8, 0,2,1));
    vecs.push_back(mk(0,1,0,0,0, 8, 0,1,1));
    vecs.push_back(mk(0,1,0,0,0, 8, 1,1,1));
    // Step while stopped, direction down
    vecs.push_back(mk(1,0,1,0,0, 1, 0,0,0));
    vecs.push_back(mk(0,0,1,0,1,20, 9,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1, 9,0,0));
    vecs.push_back(mk(0,0,1,0,1, 1, 8,0,0));
    // Mid-count speed change
    vecs.push_back(mk(1,0,0,0,0, 1, 0,0,0));
    vecs.push_back(mk(0,1,0,0,0, 1, 0,1,0));
    vecs.push_back(mk(0,1,0,0,0, 6, 0,1,0));
    vecs.push_back(mk(0,1,0,2,0, 1, 1,1,1));
    vecs.push_back(mk(0,1,0,3,0, 1, 2,1,1));
    vecs.push_back(mk(0,1,0,3,0, 3, 5,1,1));
    // Stop in the expiry cycle: no advance
    vecs.push_back(mk(1,0,0,0,0, 1, 0,0,0));
    vecs.push_back(mk(0,1,0,0,0, 1, 0,1,0));
    vecs.push_back(mk(0,1,0,0,0, 7, 0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 1, 0,0,0));
    vecs.push_back(mk(0,1,0,0,0, 9, 1,1,1));
    // Reset during HOLD
    vecs.push_back(mk(1,0,0,3,0, 1, 0,0,0));
    vecs.push_back(mk(0,1,0,3,0, 1, 0,1,0));
    vecs.push_back(mk(0,1,0,3,0,10, 0,2,1));
    vecs.push_back(mk(1,1,0,3,0, 1, 0,0,0));
    // Hold entry going down
    vecs.push_back(mk(0,1,0,3,0, 1, 0,1,0));
    vecs.push_back(mk(0,1,0,3,0, 1, 1,1,1));
    vecs.push_back(mk(0,1,1,3,0, 1, 0,2,1));
    vecs.push_back(mk(0,1,1,3,0, 2, 0,1,1));
    vecs.push_back(mk(0,1,1,3,0, 1, 9,1,1));

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; run = vecs[i].run; dir = vecs[i].dir;
      speed = vecs[i].speed; step = vecs[i].step;
      clock_n(vecs[i].ncyc);
      check($sformatf("vec%0d_f", i), f, vecs[i].exp_f);
      check($sformatf("vec%0d_e", i), e, (vecs[i].exp_f + 1) % MSG_LEN);
      check($sformatf("vec%0d_a", i), a, (vecs[i].exp_f + 5) % MSG_LEN);
      check($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
      check($sformatf("vec%0d_tick", i), tick, vecs[i].exp_tick);
    end

    // Randomized run against the model
    reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      run   = ($urandom_range(0, 9) != 0);
      step  = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      if ($urandom_range(0, 29) == 0) speed = 2'($urandom_range(0, 3));
      clock_n(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
